seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 164 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Three-digit multiplexed 7-segment scanner: BLANK/DRIVE slot FSM, frame-synchronous
// display update, leading-zero blanking and dash display for invalid digits.
module seg_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int LZB       = 1
) (
  input  logic       iCLK_50,
  input  logic       iRST_n,
  input  logic [7:0] iBCD,
  input  logic [1:0] iHUND,
  input  logic       iLOAD,
  output logic [6:0] oSEG,
  output logic [2:0] oDIG,
  output logic       oFRAME
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - BLANK_CYC - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    pend_q, pend_d;
  logic [9:0]    disp_q, disp_d;
  logic          first_q, first_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    dig_q, dig_d;
  logic          frame_q, frame_d;
  logic          boundary_s;
  logic [3:0]    digit_s;
  logic          blank_s;

  // Active-low decode; anything outside 0-9 renders as a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // State register: slot FSM, digit index and slot counter.
  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= ST_BLANK;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: counter clears on every state change and nowhere else.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end else begin
          state_d = ST_BLANK;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q >= 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      default: begin
        state_d = ST_BLANK;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // Frame boundary: the first edge out of reset, or re-entering BLANK at index 0.
  always_comb begin
    first_d    = 1'b0;
    boundary_s = first_q
               | ((state_q == ST_DRIVE) && (state_d == ST_BLANK) && (idx_d == 2'd0));
    if (iLOAD) begin
      pend_d = {iHUND, iBCD};
    end else begin
      pend_d = pend_q;
    end
    if (boundary_s) begin
      disp_d = pend_q;
    end else begin
      disp_d = disp_q;
    end
    frame_d = boundary_s;
  end

  // Output logic: slot pattern from current state/index, registered one cycle later.
  always_comb begin
    case (idx_q)
      2'd0:    digit_s = disp_q[3:0];
      2'd1:    digit_s = disp_q[7:4];
      2'd2:    digit_s = (disp_q[9:8] == 2'd3) ? 4'hF : {2'b00, disp_q[9:8]};
      default: digit_s = 4'hF;
    endcase
    blank_s = (LZB != 0)
            && (((idx_q == 2'd2) && (disp_q[9:8] == 2'd0))
             || ((idx_q == 2'd1) && (disp_q[9:8] == 2'd0) && (disp_q[7:4] == 4'd0)));
    if ((state_q == ST_DRIVE) && !blank_s) begin
      dig_d = ~(3'b001 << idx_q);
      seg_d = seg_decode(digit_s);
    end else begin
      dig_d = 3'b111;
      seg_d = 7'h7F;
    end
  end

  // Data and output registers.
  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      pend_q  <= 10'd0;
      disp_q  <= 10'd0;
      first_q <= 1'b1;
      seg_q   <= 7'h7F;
      dig_q   <= 3'b111;
      frame_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      first_q <= first_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
    end
  end

  assign oSEG   = seg_q;
  assign oDIG   = dig_q;
  assign oFRAME = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: two scanners (LZB=1 and LZB=0) checked every cycle against a
// cycle-count model of the scan schedule and frame-synchronous display update.
module tb_seg_scan_driver;

  localparam int SD = 10;
  localparam int BC = 2;
  localparam int FR = 3 * SD;

  typedef struct {
    logic [9:0] a;
    logic [9:0] b;
    logic       f;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] bcd;
  logic [1:0] hund;
  logic       ld;
  logic [6:0] seg1, seg0;
  logic [2:0] dig1, dig0;
  logic       frm1, frm0;

  exp_t       q[$];
  event       chk_ev;
  int         total = 0;
  int         bad = 0;
  int         n = 0;
  logic [9:0] pend_m = 10'd0;
  logic [9:0] disp_m = 10'd0;

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZB(1)) dut1 (
    .iCLK_50(clk), .iRST_n(rst_n), .iBCD(bcd), .iHUND(hund), .iLOAD(ld),
    .oSEG(seg1), .oDIG(dig1), .oFRAME(frm1)
  );

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZB(0)) dut0 (
    .iCLK_50(clk), .iRST_n(rst_n), .iBCD(bcd), .iHUND(hund), .iLOAD(ld),
    .oSEG(seg0), .oDIG(dig0), .oFRAME(frm0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0:       return 7'h40;
      1:       return 7'h79;
      2:       return 7'h24;
      3:       return 7'h30;
      4:       return 7'h19;
      5:       return 7'h12;
      6:       return 7'h02;
      7:       return 7'h78;
      8:       return 7'h00;
      9:       return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Expected {dig, seg} for a cycle whose scan phase is p (0..FR-1) showing value d.
  function automatic logic [9:0] model_out(input int p, input logic [9:0] d, input bit lzb);
    int slot, h, t, o, v;
    logic [2:0] en;
    slot = p / SD;
    h = int'(d[9:8]);
    t = int'(d[7:4]);
    o = int'(d[3:0]);
    if ((p % SD) < BC) return {3'b111, 7'h7F};
    if (lzb && ((slot == 2 && h == 0) || (slot == 1 && h == 0 && t == 0))) return {3'b111, 7'h7F};
    v = (slot == 0) ? o : (slot == 1) ? t : ((h == 3) ? 15 : h);
    en = 3'b001 << slot;
    return {~en, seg_of(v)};
  endfunction

  // Monitor: pops one expectation per presented output sample and compares both DUTs.
  always begin
    exp_t e;
    @(negedge clk or chk_ev);
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if ({dig1, seg1, frm1} !== {e.a, e.f}) begin
        bad++;
        $display("FAIL out_lzb1 n=%0d got dig=%b seg=%h frame=%b want dig=%b seg=%h frame=%b",
                 n, dig1, seg1, frm1, e.a[9:7], e.a[6:0], e.f);
      end
      total++;
      if ({dig0, seg0, frm0} !== {e.b, e.f}) begin
        bad++;
        $display("FAIL out_lzb0 n=%0d got dig=%b seg=%h frame=%b want dig=%b seg=%h frame=%b",
                 n, dig0, seg0, frm0, e.b[9:7], e.b[6:0], e.f);
      end
    end
  end

  // One clock of stimulus; the model predicts the outputs after the coming edge.
  task automatic step(input bit l, input logic [1:0] h, input logic [7:0] b);
    exp_t e;
    int p;
    bit bnd;
    ld = l;
    hund = h;
    bcd = b;
    p = n % FR;
    e.a = model_out(p, disp_m, 1'b1);
    e.b = model_out(p, disp_m, 1'b0);
    bnd = (n == 0) || (((n + 1) % FR) == 0);
    e.f = bnd;
    if (bnd) disp_m = pend_m;
    if (l) pend_m = {h, b};
    q.push_back(e);
    n++;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      step(1'b0, 2'($urandom_range(0, 3)), 8'($urandom));
    end
  endtask

  task automatic load_at(input int phase, input logic [1:0] h, input logic [7:0] b);
    while ((n % FR) != phase) idle(1);
    step(1'b1, h, b);
  endtask

  task automatic hold_reset(input int cyc);
    exp_t e;
    e.a = {3'b111, 7'h7F};
    e.b = {3'b111, 7'h7F};
    e.f = 1'b0;
    ld = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      q.push_back(e);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    n = 0;
    pend_m = 10'd0;
    disp_m = 10'd0;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b1;
    ld = 1'b0;
    hund = 2'd0;
    bcd = 8'd0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1;
    hold_reset(3);
    release_reset();
    idle(35);

    // Directed loads, including boundary-coincident ones (phase FR-1).
    load_at(15, 2'd1, 8'h23);
    idle(70);
    load_at(5, 2'd0, 8'h07);
    idle(70);
    load_at(20, 2'd0, 8'h00);
    idle(70);
    load_at(FR - 1, 2'd2, 8'h5A);
    idle(70);
    load_at(12, 2'd0, 8'h45);
    load_at(FR - 1, 2'd1, 8'h99);
    idle(95);

    // Asynchronous reset during DRIVE of index 1, with a load still pending.
    load_at(14, 2'd2, 8'h88);
    idle(1);
    rst_n = 1'b0;
    e.a = {3'b111, 7'h7F};
    e.b = {3'b111, 7'h7F};
    e.f = 1'b0;
    q.push_back(e);
    #1;
    ->chk_ev;
    #1;
    @(negedge clk);
    #1;
    hold_reset(2);
    release_reset();
    idle(65);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        step(1'b1, 2'($urandom_range(0, 3)), 8'($urandom));
      end else begin
        idle(1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
